alu_mul_sequencer: RTL and testbench

Multi-cycle unsigned shift-and-add multiplier controller that borrows the shared ALU for its additions.
- On a start request it takes ownership of the ALU adder, sequences WIDTH iterations and returns a 2*WIDTH-bit product.
- Sits beside the ALU at top level. While o_alu_own is high, a top-level mux selects this block's op/operand/latch outputs into the ALU in place of the instruction decoder's.
- Its internal partial-product shifting is local; only the add step uses the ALU.

---
 rtl/alu_mul_sequencer_pkg.sv | 19 +
 rtl/alu_mul_sequencer.sv | 116 +++++++++++
 tb/tb_alu_mul_sequencer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mul_sequencer_pkg.sv
// Shared constants for the multiply sequencer: the ALU control-word opcodes it
// borrows and the sequencer's own state encoding.
package alu_mul_sequencer_pkg;

    // ALU opcode field, mirrored from the shared control-word constants
    localparam int ALU_OP_WIDTH = 4;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_PASS_A = 4'h0;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD    = 4'h2;

    // Sequencer states; only ADD hands the ALU inputs over to this block
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADD   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } mul_state_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add unsigned multiplier controller. The partial product lives in
// {acc, low}; each add step borrows the shared ALU adder, and the carry the
// ALU latches during that step is shifted into the top of acc on the next
// SHIFT, so the 2*WIDTH-bit product is exact.
module alu_mul_sequencer
    import alu_mul_sequencer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic                    i_start,
    input  logic [WIDTH-1:0]        i_multiplicand,
    input  logic [WIDTH-1:0]        i_multiplier,
    input  logic [WIDTH-1:0]        i_alu_data,
    input  logic                    i_alu_carry,
    output logic                    o_alu_own,
    output logic [ALU_OP_WIDTH-1:0] o_alu_op,
    output logic [WIDTH-1:0]        o_alu_a,
    output logic [WIDTH-1:0]        o_alu_t,
    output logic                    o_alu_latch_flags,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [2*WIDTH-1:0]      o_product
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

    mul_state_t       state, state_next;
    logic [WIDTH-1:0] acc, acc_next;
    logic [WIDTH-1:0] low, low_next;
    logic [WIDTH-1:0] mcand, mcand_next;
    logic [CNT_W-1:0] count, count_next;
    logic             added, added_next;
    logic             carry_in;

    // Register all sequencer state; nothing moves unless the global enable is high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            acc   <= '0;
            low   <= '0;
            mcand <= '0;
            count <= '0;
            added <= 1'b0;
        end else if (clk_en) begin
            state <= state_next;
            acc   <= acc_next;
            low   <= low_next;
            mcand <= mcand_next;
            count <= count_next;
            added <= added_next;
        end
    end

    // Next-state and datapath update; the carry is only meaningful if this
    // iteration actually went through the ALU, otherwise a stale flag would leak in
    always_comb begin
        state_next = state;
        acc_next   = acc;
        low_next   = low;
        mcand_next = mcand;
        count_next = count;
        added_next = added;
        carry_in   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    acc_next   = '0;
                    low_next   = i_multiplier;
                    mcand_next = i_multiplicand;
                    count_next = '0;
                    added_next = 1'b0;
                    state_next = i_multiplier[0] ? ST_ADD : ST_SHIFT;
                end
            end
            ST_ADD: begin
                acc_next   = i_alu_data;
                added_next = 1'b1;
                state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                carry_in              = added ? i_alu_carry : 1'b0;
                {acc_next, low_next}  = {carry_in, acc, low[WIDTH-1:1]};
                added_next            = 1'b0;
                if (count == LAST_COUNT) begin
                    state_next = ST_DONE;
                end else begin
                    count_next = count + CNT_W'(1);
                    state_next = low[1] ? ST_ADD : ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs depend on registered state only, so i_start never reaches them combinationally
    always_comb begin
        o_alu_own         = (state == ST_ADD);
        o_alu_latch_flags = (state == ST_ADD);
        o_alu_op          = ALU_ADD;
        o_alu_a           = acc;
        o_alu_t           = mcand;
        o_busy            = (state != ST_IDLE);
        o_done            = (state == ST_DONE);
        o_product         = {acc, low};
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer: wraps the block with a small shared
// ALU and the top-level operand mux, then runs hand-computed multiplies.
module tb_alu_mul_sequencer;
    import alu_mul_sequencer_pkg::*;

    logic        clk;
    logic        rst;
    logic        clk_en;
    logic        i_start;
    logic [7:0]  i_multiplicand;
    logic [7:0]  i_multiplier;
    logic [7:0]  alu_data;
    logic        alu_carry;
    logic        alu_zero;
    logic        alu_odd;
    logic        o_alu_own;
    logic [ALU_OP_WIDTH-1:0] o_alu_op;
    logic [7:0]  o_alu_a;
    logic [7:0]  o_alu_t;
    logic        o_alu_latch_flags;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_product;

    logic [7:0]  decA;
    logic [7:0]  decT;
    logic [ALU_OP_WIDTH-1:0] decOp;
    logic        decLatch;

    logic [7:0]  aluA;
    logic [7:0]  aluT;
    logic [ALU_OP_WIDTH-1:0] aluOp;
    logic        aluLatch;
    logic [8:0]  aluFull;

    int testsRun;
    int testsFailed;

    alu_mul_sequencer #(.WIDTH(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .clk_en            (clk_en),
        .i_start           (i_start),
        .i_multiplicand    (i_multiplicand),
        .i_multiplier      (i_multiplier),
        .i_alu_data        (alu_data),
        .i_alu_carry       (alu_carry),
        .o_alu_own         (o_alu_own),
        .o_alu_op          (o_alu_op),
        .o_alu_a           (o_alu_a),
        .o_alu_t           (o_alu_t),
        .o_alu_latch_flags (o_alu_latch_flags),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .o_product         (o_product)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Top-level operand mux: the sequencer replaces the decoder while it owns the ALU
    always_comb begin
        aluA     = o_alu_own ? o_alu_a : decA;
        aluT     = o_alu_own ? o_alu_t : decT;
        aluOp    = o_alu_own ? o_alu_op : decOp;
        aluLatch = o_alu_own ? o_alu_latch_flags : decLatch;
        aluFull  = (aluOp == ALU_ADD) ? ({1'b0, aluA} + {1'b0, aluT}) : {1'b0, aluA};
        alu_data = aluFull[7:0];
    end

    // Minimal ALU flag register: latched on enabled edges when asked to
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_carry <= 1'b0;
            alu_zero  <= 1'b0;
            alu_odd   <= 1'b0;
        end else if (clk_en && aluLatch) begin
            alu_carry <= aluFull[8];
            alu_zero  <= (aluFull[7:0] == 8'h00);
            alu_odd   <= aluFull[0];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Start one multiply from a negedge and follow it until DONE has been left.
    // Latency is counted in enabled edges after the start edge up to DONE entry.
    task automatic applyStimulus(
        input  logic [7:0]  m,
        input  logic [7:0]  q,
        input  bit          toggle,
        input  bit          inject,
        output int          latency,
        output int          rawEdges,
        output int          ownCycles,
        output int          doneCycles,
        output int          doneRaw,
        output logic [15:0] prod,
        output bit          busySeen
    );
        int  k;
        int  enEdges;
        bit  finished;
        bit  latSet;
        i_multiplicand = m;
        i_multiplier   = q;
        i_start        = 1'b1;
        clk_en         = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_start    = 1'b0;
        latency    = 0;
        rawEdges   = 0;
        ownCycles  = 0;
        doneCycles = 0;
        doneRaw    = 0;
        prod       = '0;
        busySeen   = o_busy;
        finished   = 1'b0;
        latSet     = 1'b0;
        enEdges    = 0;
        k          = 0;
        while (!finished && k < 100) begin
            k++;
            clk_en = toggle ? (k % 2 == 0) : 1'b1;
            if (inject && k == 3) begin
                i_start        = 1'b1;
                i_multiplicand = 8'hFF;
                i_multiplier   = 8'hFF;
            end
            if (inject && k == 5) begin
                i_start = 1'b0;
            end
            if (o_done) begin
                doneRaw++;
                if (!latSet) begin
                    latSet   = 1'b1;
                    latency  = enEdges;
                    rawEdges = k - 1;
                end
            end
            if (clk_en) begin
                ownCycles  += int'(o_alu_own);
                doneCycles += int'(o_done);
                if (o_done) begin
                    finished = 1'b1;
                    prod     = o_product;
                end
            end
            @(posedge clk);
            if (clk_en) enEdges++;
            @(negedge clk);
        end
        clk_en = 1'b1;
        if (!finished) begin
            checkOutput("timeout", 32'd0, 32'd1);
        end
    endtask

    // Run one multiply and check product, timing, ALU ownership and the idle aftermath
    task automatic runAndCheck(
        input string       name,
        input logic [7:0]  m,
        input logic [7:0]  q,
        input bit          toggle,
        input bit          inject,
        input logic [15:0] expProd,
        input int          expLat,
        input int          expRaw,
        input int          expOwn
    );
        int          lat, raw, own, dn, dnRaw;
        logic [15:0] prod;
        bit          busySeen;
        applyStimulus(m, q, toggle, inject, lat, raw, own, dn, dnRaw, prod, busySeen);
        checkOutput({name, "_busy"},    32'(busySeen), 32'd1);
        checkOutput({name, "_product"}, 32'(prod), 32'(expProd));
        checkOutput({name, "_latency"}, 32'(lat), 32'(expLat));
        checkOutput({name, "_raw"},     32'(raw), 32'(expRaw));
        checkOutput({name, "_own"},     32'(own), 32'(expOwn));
        checkOutput({name, "_done"},    32'(dn), 32'd1);
        checkOutput({name, "_donehold"}, 32'(dnRaw), toggle ? 32'd2 : 32'd1);
        checkOutput({name, "_idlebusy"}, 32'(o_busy), 32'd0);
        checkOutput({name, "_holdprod"}, 32'(o_product), 32'(expProd));
    endtask

    // Directed sequence: reset state, normal runs, edge cases, enable gating, ignored starts, reset abort
    initial begin
        testsRun       = 0;
        testsFailed    = 0;
        rst            = 1'b1;
        clk_en         = 1'b0;
        i_start        = 1'b0;
        i_multiplicand = 8'h00;
        i_multiplier   = 8'h00;
        decA           = 8'h00;
        decT           = 8'h00;
        decOp          = ALU_PASS_A;
        decLatch       = 1'b0;
        repeat (2) @(negedge clk);

        checkOutput("rst_op",      32'(o_alu_op), 32'(ALU_ADD));
        checkOutput("rst_own",     32'(o_alu_own), 32'd0);
        checkOutput("rst_latch",   32'(o_alu_latch_flags), 32'd0);
        checkOutput("rst_busy",    32'(o_busy), 32'd0);
        checkOutput("rst_done",    32'(o_done), 32'd0);
        checkOutput("rst_product", 32'(o_product), 32'd0);
        checkOutput("rst_a",       32'(o_alu_a), 32'd0);
        checkOutput("rst_t",       32'(o_alu_t), 32'd0);

        rst    = 1'b0;
        clk_en = 1'b1;
        @(negedge clk);

        runAndCheck("m5q3",  8'h05, 8'h03, 1'b0, 1'b0, 16'h000F, 10, 10, 2);
        runAndCheck("mffqff", 8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFE01, 16, 16, 8);

        // Give the flags a known value through the decoder path, then a Q=0 multiply must leave them alone
        decA     = 8'h80;
        decT     = 8'h80;
        decOp    = ALU_ADD;
        decLatch = 1'b1;
        @(negedge clk);
        decLatch = 1'b0;
        decOp    = ALU_PASS_A;
        checkOutput("flags_preset", 32'({alu_carry, alu_zero, alu_odd}), 32'b110);
        runAndCheck("ma7q0", 8'hA7, 8'h00, 1'b0, 1'b0, 16'h0000, 8, 8, 0);
        checkOutput("flags_kept", 32'({alu_carry, alu_zero, alu_odd}), 32'b110);

        runAndCheck("toggle", 8'h03, 8'h06, 1'b1, 1'b0, 16'h0012, 10, 20, 2);
        runAndCheck("inject", 8'h07, 8'h09, 1'b0, 1'b1, 16'h003F, 10, 10, 2);
        runAndCheck("backtoback", 8'h02, 8'h02, 1'b0, 1'b0, 16'h0004, 9, 9, 1);
        runAndCheck("m80q81", 8'h80, 8'h81, 1'b0, 1'b0, 16'h4080, 10, 10, 2);

        // Abort a multiply from SHIFT with an asynchronous reset mid-cycle
        i_multiplicand = 8'h05;
        i_multiplier   = 8'h03;
        i_start        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_pre_busy",    32'(o_busy), 32'd1);
        checkOutput("abort_pre_product", 32'(o_product), 32'h0503);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort_busy",    32'(o_busy), 32'd0);
        checkOutput("abort_own",     32'(o_alu_own), 32'd0);
        checkOutput("abort_product", 32'(o_product), 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);

        runAndCheck("after_rst", 8'hFF, 8'h80, 1'b0, 1'b0, 16'h7F80, 9, 9, 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
